// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the fetch-side pipeline control.
//               - IRSrcIF mux select encodings
//               - hazard controller FSM state type
//               - canonical NOP instruction word
//               - helper that computes the counter preload for a slot count
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // IF instruction-source mux selects (2'b11 is never driven)
  localparam logic [1:0] IRSRC_PASS   = 2'b00;
  localparam logic [1:0] IRSRC_NOP    = 2'b01;
  localparam logic [1:0] IRSRC_REPLAY = 2'b10;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_REPLAY = 2'd2,
    ST_FLUSH  = 2'd3
  } hz_state_t;

  // The cycle that detects a hazard already produces the first NOP, and the
  // state machine leaves its holding state on cnt==0, so a run of N NOPs
  // needs a preload of N-2. Slot counts of 1 never enter the holding state.
  function automatic logic [CNT_W-1:0] slot_cnt_init(input int unsigned slots);
    if (slots > 1) begin
      return CNT_W'(slots - 2);
    end
    return '0;
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/lu_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : lu_hazard_detect
// Description : Combinational load-use hazard compare. Flags when the load
//               in EX writes a register that the instruction in ID reads.
//               Register 0 is hard-wired, so a load to it never conflicts.
// Ports       : ex_mem_read - EX instruction is a load
//               ex_rt       - load destination in EX
//               id_rs       - rs of instruction in ID
//               id_rt       - rt of instruction in ID
//               id_uses_rt  - ID instruction actually reads rt
//               lu_hazard   - hazard present this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module lu_hazard_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             lu_hazard
);

  logic rs_match;
  logic rt_match;
  logic dst_nonzero;

  assign dst_nonzero = (ex_rt != '0);
  assign rs_match    = (ex_rt == id_rs);
  assign rt_match    = id_uses_rt && (ex_rt == id_rt);
  assign lu_hazard   = ex_mem_read && dst_nonzero && (rs_match || rt_match);

endmodule : lu_hazard_detect
`default_nettype wire

// File: rtl/if_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : if_hazard_ctrl
// Description : Fetch-side hazard controller for the 5-stage pipeline.
//               Load-use hazards insert NOP bubbles while holding the PC and
//               then replay the fetched word that was captured on detection.
//               Taken BNEs resolved in EX insert NOP slots while the PC takes
//               the branch target. A branch always overrides a stall, replay
//               or flush in progress. Outputs are combinational so a hazard
//               acts in the cycle it is detected.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               if_instr          - word fetched this cycle
//               id_rs/id_rt       - source registers of the ID instruction
//               id_uses_rt        - ID instruction reads rt
//               ex_mem_read/ex_rt - load in EX and its destination
//               ex_bne_taken      - BNE in EX resolved taken
//               IRSrcIF           - IF instruction-source mux select
//               replay_instr      - held word for the replay mux input
//               pc_write          - PC update enable
//               if_id_write       - IF/ID register enable
//               busy              - controller is not in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module if_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned FLUSH_SLOTS      = 2,
  parameter int unsigned REG_W            = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_instr,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_bne_taken,
  output logic [1:0]       IRSrcIF,
  output logic [31:0]      replay_instr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             busy
);

  localparam logic [CNT_W-1:0] STALL_INIT = slot_cnt_init(LOAD_USE_BUBBLES);
  localparam logic [CNT_W-1:0] FLUSH_INIT = slot_cnt_init(FLUSH_SLOTS);

  hz_state_t        state;
  hz_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [31:0]      replay_reg;
  logic [31:0]      replay_nxt;
  logic             lu_hazard;

  lu_hazard_detect #(
    .REG_W (REG_W)
  ) u_lu_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .lu_hazard   (lu_hazard)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      cnt        <= '0;
      replay_reg <= NOP_WORD;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      replay_reg <= replay_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    replay_nxt  = replay_reg;
    IRSrcIF     = IRSRC_PASS;
    pc_write    = 1'b1;
    if_id_write = 1'b1;

    if (ex_bne_taken) begin
      // Branch wins from any state; the PC keeps moving to the target and
      // any held replay word is simply never selected again.
      IRSrcIF  = IRSRC_NOP;
      pc_write = 1'b1;
      if (FLUSH_SLOTS > 1) begin
        state_nxt = ST_FLUSH;
        cnt_nxt   = FLUSH_INIT;
      end else begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (lu_hazard) begin
            IRSrcIF    = IRSRC_NOP;
            pc_write   = 1'b0;
            replay_nxt = if_instr;
            if (LOAD_USE_BUBBLES > 1) begin
              state_nxt = ST_STALL;
              cnt_nxt   = STALL_INIT;
            end else begin
              state_nxt = ST_REPLAY;
            end
          end
        end

        ST_STALL: begin
          IRSrcIF  = IRSRC_NOP;
          pc_write = 1'b0;
          if (cnt == '0) begin
            state_nxt = ST_REPLAY;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end

        ST_REPLAY: begin
          IRSrcIF   = IRSRC_REPLAY;
          pc_write  = 1'b1;
          state_nxt = ST_RUN;
          // A fresh hazard against the replayed slot bubbles again but keeps
          // the word already held, since the PC never advanced past it.
          if (lu_hazard) begin
            IRSrcIF  = IRSRC_NOP;
            pc_write = 1'b0;
            if (LOAD_USE_BUBBLES > 1) begin
              state_nxt = ST_STALL;
              cnt_nxt   = STALL_INIT;
            end else begin
              state_nxt = ST_REPLAY;
            end
          end
        end

        ST_FLUSH: begin
          // ID holds a squashed instruction, so load-use is not examined.
          IRSrcIF  = IRSRC_NOP;
          pc_write = 1'b1;
          if (cnt == '0) begin
            state_nxt = ST_RUN;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end

        default: begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      endcase
    end

    // While reset is held, load a NOP into IF/ID and freeze the PC.
    if (rst) begin
      IRSrcIF  = IRSRC_NOP;
      pc_write = 1'b0;
    end
  end

  assign replay_instr = replay_reg;
  assign busy         = !rst && (state != ST_RUN);

endmodule : if_hazard_ctrl
`default_nettype wire

// File: tb/tb_if_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_hazard_ctrl
// Description : Scoreboard bench for if_hazard_ctrl. Two instances share the
//               same inputs: dut_a uses LOAD_USE_BUBBLES=1, FLUSH_SLOTS=2 and
//               dut_b uses LOAD_USE_BUBBLES=3, FLUSH_SLOTS=2. The stimulus
//               process pushes hand-computed expectations tagged with the
//               instance they apply to; a monitor pops and compares them on
//               the falling edge of every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_hazard_ctrl;

  localparam bit DA = 1'b0;
  localparam bit DB = 1'b1;
  localparam logic [1:0] PASS = 2'b00;
  localparam logic [1:0] NOP  = 2'b01;
  localparam logic [1:0] RPL  = 2'b10;
  localparam logic [31:0] BG  = 32'h0BAD_F00D;

  logic        clk;
  logic        rst;
  logic [31:0] if_instr;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_bne_taken;

  logic [1:0]  irsrc_a, irsrc_b;
  logic [31:0] rinstr_a, rinstr_b;
  logic        pcw_a, pcw_b;
  logic        ifid_a, ifid_b;
  logic        busy_a, busy_b;

  typedef struct {
    bit          sel;
    string       name;
    logic [1:0]  irsrc;
    logic        pcw;
    logic        busy;
    logic [31:0] rinstr;
    bit          chk_r;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  if_hazard_ctrl #(
    .LOAD_USE_BUBBLES (1),
    .FLUSH_SLOTS      (2),
    .REG_W            (5)
  ) dut_a (
    .clk          (clk),
    .rst          (rst),
    .if_instr     (if_instr),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .ex_bne_taken (ex_bne_taken),
    .IRSrcIF      (irsrc_a),
    .replay_instr (rinstr_a),
    .pc_write     (pcw_a),
    .if_id_write  (ifid_a),
    .busy         (busy_a)
  );

  if_hazard_ctrl #(
    .LOAD_USE_BUBBLES (3),
    .FLUSH_SLOTS      (2),
    .REG_W            (5)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .if_instr     (if_instr),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .ex_bne_taken (ex_bne_taken),
    .IRSrcIF      (irsrc_b),
    .replay_instr (rinstr_b),
    .pc_write     (pcw_b),
    .if_id_write  (ifid_b),
    .busy         (busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // --------------------------------------------------------------------------
  // Monitor: the outputs are valid every cycle, so every expectation queued
  // during a cycle is checked at that cycle's falling edge.
  // --------------------------------------------------------------------------
  initial begin
    exp_t        e;
    logic [1:0]  a_irs;
    logic [31:0] a_ri;
    logic        a_pcw, a_ifid, a_busy;
    bit          bad;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel == DA) begin
          a_irs = irsrc_a; a_ri = rinstr_a; a_pcw = pcw_a;
          a_ifid = ifid_a; a_busy = busy_a;
        end else begin
          a_irs = irsrc_b; a_ri = rinstr_b; a_pcw = pcw_b;
          a_ifid = ifid_b; a_busy = busy_b;
        end
        bad = (a_irs !== e.irsrc) || (a_pcw !== e.pcw) ||
              (a_ifid !== 1'b1) || (a_busy !== e.busy) ||
              (e.chk_r && (a_ri !== e.rinstr));
        n_tests++;
        if (bad) begin
          n_fail++;
          $display("FAIL %s (dut_%s): got IRSrcIF=%b pc_write=%b if_id_write=%b busy=%b replay=%h; want IRSrcIF=%b pc_write=%b if_id_write=1 busy=%b replay=%h%s",
                   e.name, (e.sel == DA) ? "a" : "b", a_irs, a_pcw, a_ifid,
                   a_busy, a_ri, e.irsrc, e.pcw, e.busy, e.rinstr,
                   e.chk_r ? "" : " (replay not checked)");
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic drv(input logic r, input logic [31:0] ins,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic mr,
                     input logic [4:0] ert, input logic bne);
    rst = r; if_instr = ins; id_rs = rs; id_rt = rt;
    id_uses_rt = urt; ex_mem_read = mr; ex_rt = ert; ex_bne_taken = bne;
  endtask

  task automatic idle();
    drv(1'b0, BG, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Load in EX to r5, ID reads r5 through rs.
  task automatic hazard(input logic [31:0] ins);
    drv(1'b0, ins, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
  endtask

  task automatic branch();
    drv(1'b0, BG, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
  endtask

  task automatic ex(input bit sel, input string nm, input logic [1:0] irs,
                    input logic pcw, input logic bsy,
                    input logic [31:0] ri, input bit chk);
    exp_t e;
    e.sel = sel; e.name = nm; e.irsrc = irs; e.pcw = pcw;
    e.busy = bsy; e.rinstr = ri; e.chk_r = chk;
    sb.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Directed vectors
  // --------------------------------------------------------------------------
  initial begin
    // Reset held 2 cycles with a taken branch present: reset wins.
    drv(1'b1, BG, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    ex(DA, "rst_c0", NOP, 1'b0, 1'b0, 32'h0, 1'b0);
    ex(DB, "rst_c0", NOP, 1'b0, 1'b0, 32'h0, 1'b0);
    nxt();
    ex(DA, "rst_c1", NOP, 1'b0, 1'b0, 32'h0, 1'b1);
    ex(DB, "rst_c1", NOP, 1'b0, 1'b0, 32'h0, 1'b1);
    nxt();
    idle();
    ex(DA, "post_rst", PASS, 1'b1, 1'b0, 32'h0, 1'b1);
    ex(DB, "post_rst", PASS, 1'b1, 1'b0, 32'h0, 1'b1);
    nxt();

    // ---- dut_a: basic load-use, one bubble then replay ----
    hazard(32'h1234_5678);
    ex(DA, "lu_bubble", NOP, 1'b0, 1'b0, 32'h0, 1'b1);
    nxt();
    idle();
    ex(DA, "lu_replay", RPL, 1'b1, 1'b1, 32'h1234_5678, 1'b1);
    nxt();
    ex(DA, "lu_resume", PASS, 1'b1, 1'b0, 32'h1234_5678, 1'b1);
    nxt();

    // Load to $zero never stalls.
    drv(1'b0, BG, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    ex(DA, "zero_dst", PASS, 1'b1, 1'b0, 32'h0, 1'b0);
    nxt();
    // rt matches but is not read.
    drv(1'b0, BG, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0);
    ex(DA, "rt_unused", PASS, 1'b1, 1'b0, 32'h0, 1'b0);
    nxt();
    // Same compare with rt read: stall, then replay.
    drv(1'b0, 32'hCAFE_F00D, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
    ex(DA, "rt_used", NOP, 1'b0, 1'b0, 32'h0, 1'b0);
    nxt();
    idle();
    ex(DA, "rt_replay", RPL, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1);
    nxt();
    ex(DA, "rt_resume", PASS, 1'b1, 1'b0, 32'h0, 1'b0);
    nxt();

    // Taken BNE: exactly two NOP slots with PC advancing.
    branch();
    ex(DA, "bne_slot0", NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    nxt();
    idle();
    ex(DA, "bne_slot1", NOP, 1'b1, 1'b1, 32'h0, 1'b0);
    nxt();
    ex(DA, "bne_done", PASS, 1'b1, 1'b0, 32'h0, 1'b0);
    nxt();

    // Load-use during FLUSH is ignored.
    branch();
    ex(DA, "flu_slot0", NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    nxt();
    hazard(32'h5555_AAAA);
    ex(DA, "flu_ign_lu", NOP, 1'b1, 1'b1, 32'h0, 1'b0);
    nxt();
    idle();
    ex(DA, "flu_done", PASS, 1'b1, 1'b0, 32'h0, 1'b0);
    nxt();

    // New hazard in the REPLAY cycle keeps the held word.
    hazard(32'h1111_1111);
    ex(DA, "rr_bubble0", NOP, 1'b0, 1'b0, 32'h0, 1'b0);
    nxt();
    hazard(32'h2222_2222);
    ex(DA, "rr_rehaz", NOP, 1'b0, 1'b1, 32'h1111_1111, 1'b1);
    nxt();
    idle();
    ex(DA, "rr_replay", RPL, 1'b1, 1'b1, 32'h1111_1111, 1'b1);
    nxt();
    ex(DA, "rr_resume", PASS, 1'b1, 1'b0, 32'h0, 1'b0);
    nxt();

    // Branch in REPLAY cycle wins over the replay.
    hazard(32'h3333_3333);
    ex(DA, "br_rpl_lu", NOP, 1'b0, 1'b0, 32'h0, 1'b0);
    nxt();
    branch();
    ex(DA, "br_rpl_bne", NOP, 1'b1, 1'b1, 32'h0, 1'b0);
    nxt();
    idle();
    ex(DA, "br_rpl_fl", NOP, 1'b1, 1'b1, 32'h0, 1'b0);
    nxt();
    ex(DA, "br_rpl_done", PASS, 1'b1, 1'b0, 32'h0, 1'b0);
    nxt();

    // Reset in the middle of FLUSH.
    branch();
    ex(DA, "rf_slot0", NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    nxt();
    drv(1'b1, BG, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    ex(DA, "rf_in_rst", NOP, 1'b0, 1'b0, 32'h0, 1'b0);
    nxt();
    idle();
    ex(DA, "rf_run", PASS, 1'b1, 1'b0, 32'h0, 1'b1);
    nxt();
    // A fresh branch shows the counter restarted from a clean state.
    branch();
    ex(DA, "rf_bne0", NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    nxt();
    idle();
    ex(DA, "rf_bne1", NOP, 1'b1, 1'b1, 32'h0, 1'b0);
    nxt();
    ex(DA, "rf_bne_done", PASS, 1'b1, 1'b0, 32'h0, 1'b0);
    nxt();

    // ---- dut_b: realign with reset, then 3-bubble tests ----
    drv(1'b1, BG, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    ex(DB, "b_rst", NOP, 1'b0, 1'b0, 32'h0, 1'b0);
    nxt();
    idle();
    ex(DB, "b_idle", PASS, 1'b1, 1'b0, 32'h0, 1'b1);
    nxt();

    // Full load-use: three bubbles, then replay.
    hazard(32'hABCD_0001);
    ex(DB, "b_lu_n0", NOP, 1'b0, 1'b0, 32'h0, 1'b0);
    nxt();
    idle();
    ex(DB, "b_lu_n1", NOP, 1'b0, 1'b1, 32'h0, 1'b0);
    nxt();
    ex(DB, "b_lu_n2", NOP, 1'b0, 1'b1, 32'h0, 1'b0);
    nxt();
    ex(DB, "b_lu_rpl", RPL, 1'b1, 1'b1, 32'hABCD_0001, 1'b1);
    nxt();
    ex(DB, "b_lu_done", PASS, 1'b1, 1'b0, 32'h0, 1'b0);
    nxt();

    // Branch in the second STALL cycle: no replay, two NOPs, then pass.
    hazard(32'hABCD_0002);
    ex(DB, "b_bs_n0", NOP, 1'b0, 1'b0, 32'h0, 1'b0);
    nxt();
    idle();
    ex(DB, "b_bs_st1", NOP, 1'b0, 1'b1, 32'h0, 1'b0);
    nxt();
    branch();
    ex(DB, "b_bs_bne", NOP, 1'b1, 1'b1, 32'h0, 1'b0);
    nxt();
    idle();
    ex(DB, "b_bs_fl", NOP, 1'b1, 1'b1, 32'h0, 1'b0);
    nxt();
    ex(DB, "b_bs_done", PASS, 1'b1, 1'b0, 32'h0, 1'b0);
    nxt();

    nxt();
    nxt();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_if_hazard_ctrl
`default_nettype wire
